// File: rtl/vga_timing_pkg.sv
// Timing presets and helpers shared by the VGA raster generator and its axis counters.
package vga_timing_pkg;

  typedef struct packed {
    int act;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  // Industry-standard 60 Hz modes; POL 1 = positive-going sync pulse.
  localparam axis_timing_t VGA640_H  = '{act: 640,  fp: 16, sync: 96,  bp: 48};
  localparam axis_timing_t VGA640_V  = '{act: 480,  fp: 10, sync: 2,   bp: 33};
  localparam bit           VGA640_HS_POL = 1'b0;
  localparam bit           VGA640_VS_POL = 1'b0;

  localparam axis_timing_t SVGA800_H = '{act: 800,  fp: 40, sync: 128, bp: 88};
  localparam axis_timing_t SVGA800_V = '{act: 600,  fp: 1,  sync: 4,   bp: 23};
  localparam bit           SVGA800_HS_POL = 1'b1;
  localparam bit           SVGA800_VS_POL = 1'b1;

  localparam axis_timing_t SXGA_H    = '{act: 1280, fp: 48, sync: 112, bp: 248};
  localparam axis_timing_t SXGA_V    = '{act: 1024, fp: 1,  sync: 3,   bp: 38};
  localparam bit           SXGA_HS_POL = 1'b1;
  localparam bit           SXGA_VS_POL = 1'b1;

  function automatic int total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a position counter with terminal-count, first, active and sync decodes.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int N_ACT  = 1280,
  parameter int N_FP   = 48,
  parameter int N_SYNC = 112,
  parameter int N_BP   = 248,
  parameter bit POL    = 1'b1,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic          first,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int            N_TOTAL  = total(N_ACT, N_FP, N_SYNC, N_BP);
  localparam logic [CW-1:0] LAST     = CW'(N_TOTAL - 1);
  localparam logic [CW-1:0] ACT_END  = CW'(N_ACT);
  localparam logic [CW-1:0] SYNC_BEG = CW'(N_ACT + N_FP);
  localparam logic [CW-1:0] SYNC_END = CW'(N_ACT + N_FP + N_SYNC);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;
  logic          in_sync_s;

  // Next position: hold unless advancing, wrap after the last position.
  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_sync_s = (cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END);

  assign cnt    = cnt_q;
  assign first  = (cnt_q == '0);
  assign wrap   = (cnt_q == LAST);
  assign active = (cnt_q < ACT_END);
  assign sync   = POL ? in_sync_s : ~in_sync_s;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator with pixel clock-enable,
// display enable and line/frame strobes; all outputs registered and mutually aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW     = 11,
  parameter int H_ACT  = SXGA_H.act,
  parameter int H_FP   = SXGA_H.fp,
  parameter int H_SYNC = SXGA_H.sync,
  parameter int H_BP   = SXGA_H.bp,
  parameter int V_ACT  = SXGA_V.act,
  parameter int V_FP   = SXGA_V.fp,
  parameter int V_SYNC = SXGA_V.sync,
  parameter int V_BP   = SXGA_V.bp,
  parameter bit HS_POL = SXGA_HS_POL,
  parameter bit VS_POL = SXGA_VS_POL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          disp_en,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACT, V_FP, V_SYNC, V_BP);

  if (CW < 1 || H_ACT < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACT < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
    $error("vga_timing_gen: every width and timing parameter must be at least 1");
  end
  if (H_TOTAL > (2 ** CW)) begin : g_h_overflow
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (2 ** CW)) begin : g_v_overflow
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  logic [CW-1:0] h_cnt_s;
  logic [CW-1:0] v_cnt_s;
  logic          h_first_s;
  logic          v_first_s;
  logic          h_wrap_s;
  logic          v_wrap_s;
  logic          h_act_s;
  logic          v_act_s;
  logic          h_sync_s;
  logic          v_sync_s;
  logic          v_adv_s;
  logic          unused_s;

  assign v_adv_s  = ce & h_wrap_s;
  // The vertical terminal count has no consumer; the frame restarts on its own wrap.
  assign unused_s = v_wrap_s;

  vga_axis_counter #(
    .N_ACT (H_ACT),
    .N_FP  (H_FP),
    .N_SYNC(H_SYNC),
    .N_BP  (H_BP),
    .POL   (HS_POL),
    .CW    (CW)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .adv   (ce),
    .cnt   (h_cnt_s),
    .first (h_first_s),
    .wrap  (h_wrap_s),
    .active(h_act_s),
    .sync  (h_sync_s)
  );

  vga_axis_counter #(
    .N_ACT (V_ACT),
    .N_FP  (V_FP),
    .N_SYNC(V_SYNC),
    .N_BP  (V_BP),
    .POL   (VS_POL),
    .CW    (CW)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .adv   (v_adv_s),
    .cnt   (v_cnt_s),
    .first (v_first_s),
    .wrap  (v_wrap_s),
    .active(v_act_s),
    .sync  (v_sync_s)
  );

  logic          h_sync_d,      h_sync_q;
  logic          v_sync_d,      v_sync_q;
  logic          disp_en_d,     disp_en_q;
  logic [CW-1:0] pixel_x_d,     pixel_x_q;
  logic [CW-1:0] pixel_y_d,     pixel_y_q;
  logic          line_start_d,  line_start_q;
  logic          frame_start_d, frame_start_q;

  // Output stage: load the decode of the pre-advance position on ce, else hold levels.
  always_comb begin
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    disp_en_d     = disp_en_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (ce) begin
      h_sync_d      = h_sync_s;
      v_sync_d      = v_sync_s;
      disp_en_d     = h_act_s & v_act_s;
      pixel_x_d     = h_cnt_s;
      pixel_y_d     = v_cnt_s;
      line_start_d  = h_first_s;
      frame_start_d = h_first_s & v_first_s;
    end else begin
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // Output registers; reset parks the syncs at their idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync_q      <= ~HS_POL;
      v_sync_q      <= ~VS_POL;
      disp_en_q     <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      disp_en_q     <= disp_en_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_h_sync  = h_sync_q;
  assign vga_v_sync  = v_sync_q;
  assign disp_en     = disp_en_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
